// File: rtl/interrupt_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_controller_if
//  Description : Bundle of the pending-register / CPU handshake signals used
//                by interrupt_controller.
//                master : pending register + CPU side (drives Pending, Mask,
//                         Global_En, Int_Ack, Int_Return)
//                slave  : interrupt controller side (drives Int_Req, Int_Id,
//                         Int_Vector, CLR, In_Service)
//  Revision    : 1.0  initial release
// ============================================================================
interface interrupt_controller_if #(
    parameter int ADDR_W = 16
);
    logic [3:0]        Pending;
    logic [3:0]        Mask;
    logic              Global_En;
    logic              Int_Ack;
    logic              Int_Return;
    logic              Int_Req;
    logic [1:0]        Int_Id;
    logic [ADDR_W-1:0] Int_Vector;
    logic [3:0]        CLR;
    logic [3:0]        In_Service;

    modport master (
        output Pending, Mask, Global_En, Int_Ack, Int_Return,
        input  Int_Req, Int_Id, Int_Vector, CLR, In_Service
    );

    modport slave (
        input  Pending, Mask, Global_En, Int_Ack, Int_Return,
        output Int_Req, Int_Id, Int_Vector, CLR, In_Service
    );
endinterface
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_controller
//  Description : Masks 4 pending interrupt sources, selects the highest
//                priority one (bit0 highest), runs a request/acknowledge
//                handshake with the CPU supplying the handler vector, pulses
//                the pending-register clear line and tracks in-service state
//                until return-from-interrupt.
//  Ports       : CLK, Reset (sync, active-high)
//                bus (interrupt_controller_if.slave):
//                  in : Pending[3:0], Mask[3:0], Global_En, Int_Ack, Int_Return
//                  out: Int_Req, Int_Id[1:0], Int_Vector[ADDR_W-1:0],
//                       CLR[3:0], In_Service[3:0]
//  Options     : INTERRUPT_CONTROLLER_NESTING_EN - allows strictly
//                higher-priority sources to pre-empt an in-service source.
//  Revision    : 1.0  initial release
// ============================================================================
module interrupt_controller #(
    parameter int                ADDR_W        = 16,
    parameter logic [ADDR_W-1:0] VECTOR_BASE   = ADDR_W'(16'h0100),
    parameter logic [ADDR_W-1:0] VECTOR_STRIDE = ADDR_W'(16'h0010)
) (
    input  logic                  CLK,
    input  logic                  Reset,
    interrupt_controller_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t            state;
    logic              int_req;
    logic [1:0]        int_id;
    logic [ADDR_W-1:0] int_vector;
    logic [3:0]        clr;
    logic [3:0]        in_service;

    logic [3:0]        allowed;
    logic [3:0]        eligible;
    logic [1:0]        winner;
    logic [ADDR_W-1:0] winner_vector;
    logic [3:0]        in_service_popped;
    logic [3:0]        id_onehot;

`ifdef INTERRUPT_CONTROLLER_NESTING_EN
    // Isolate the lowest set In_Service bit and subtract one: this leaves
    // exactly the strictly higher-priority positions set. With nothing in
    // service the subtraction wraps to all ones.
    assign allowed = (in_service & (~in_service + 4'd1)) - 4'd1;
`else
    assign allowed = 4'b1111;
`endif

    assign eligible = bus.Pending & bus.Mask & {4{bus.Global_En}} & allowed;

    always_comb begin
        winner = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (eligible[i]) winner = 2'(i);
        end
    end

    assign winner_vector = VECTOR_BASE + VECTOR_STRIDE * ADDR_W'(winner);

    // Clearing the lowest set bit retires the highest-priority active source.
    assign in_service_popped = in_service & (in_service - 4'd1);
    assign id_onehot         = 4'b0001 << int_id;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= IDLE;
            int_req    <= 1'b0;
            int_id     <= 2'd0;
            int_vector <= '0;
            clr        <= 4'b0000;
            in_service <= 4'b0000;
        end else begin
            clr <= 4'b0000;
            case (state)
                IDLE: begin
                    if (eligible != 4'b0000) begin
                        int_req    <= 1'b1;
                        int_id     <= winner;
                        int_vector <= winner_vector;
                        state      <= REQ;
                    end
                end

                REQ: begin
                    // Request is frozen here: no re-arbitration, no withdrawal.
                    if (bus.Int_Ack) begin
                        int_req <= 1'b0;
                        clr     <= id_onehot;
                        state   <= SERVICE;
                        if (bus.Int_Return && (in_service != 4'b0000))
                            in_service <= in_service_popped | id_onehot;
                        else
                            in_service <= in_service | id_onehot;
                    end else if (bus.Int_Return && (in_service != 4'b0000)) begin
                        in_service <= in_service_popped;
                    end
                end

                SERVICE: begin
                    if (bus.Int_Return) begin
                        in_service <= in_service_popped;
                        if (in_service_popped == 4'b0000) state <= IDLE;
                    end
`ifdef INTERRUPT_CONTROLLER_NESTING_EN
                    else if (eligible != 4'b0000) begin
                        int_req    <= 1'b1;
                        int_id     <= winner;
                        int_vector <= winner_vector;
                        state      <= REQ;
                    end
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Int_Req    = int_req;
    assign bus.Int_Id     = int_id;
    assign bus.Int_Vector = int_vector;
    assign bus.CLR        = clr;
    assign bus.In_Service = in_service;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interrupt_controller
//  Description : Directed self-checking bench for interrupt_controller.
//                Inputs change 1 time unit after a rising edge; outputs are
//                sampled at the same point, i.e. reflecting the last edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_interrupt_controller;

    logic CLK   = 1'b0;
    logic Reset = 1'b1;
    int   passed = 0;
    int   total  = 0;

    interrupt_controller_if #(.ADDR_W(16)) bus ();

    interrupt_controller #(
        .ADDR_W        (16),
        .VECTOR_BASE   (16'h0100),
        .VECTOR_STRIDE (16'h0010)
    ) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset          = 1'b1;
        bus.Pending    = 4'b0000;
        bus.Mask       = 4'b1111;
        bus.Global_En  = 1'b1;
        bus.Int_Ack    = 1'b0;
        bus.Int_Return = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.Int_Req !== 1'b0) $display("FAIL rst_req: got %0h expected 0", bus.Int_Req); else passed++;
        total++; if (bus.Int_Id !== 2'd0) $display("FAIL rst_id: got %0h expected 0", bus.Int_Id); else passed++;
        total++; if (bus.Int_Vector !== 16'h0000) $display("FAIL rst_vec: got %0h expected 0", bus.Int_Vector); else passed++;
        total++; if (bus.CLR !== 4'b0000) $display("FAIL rst_clr: got %0b expected 0000", bus.CLR); else passed++;
        total++; if (bus.In_Service !== 4'b0000) $display("FAIL rst_insvc: got %0b expected 0000", bus.In_Service); else passed++;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (bus.Int_Req !== 1'b0 || bus.CLR !== 4'b0000 || bus.In_Service !== 4'b0000)
                $display("FAIL idle_quiet cyc%0d: got req=%0h clr=%0b insvc=%0b expected 0/0000/0000",
                         i, bus.Int_Req, bus.CLR, bus.In_Service);
            else passed++;
        end
    endtask

    task automatic test_basic();
        do_reset();
        bus.Pending = 4'b1010;
        tick();
        total++; if (bus.Int_Req !== 1'b1) $display("FAIL basic_req: got %0h expected 1", bus.Int_Req); else passed++;
        total++; if (bus.Int_Id !== 2'd1) $display("FAIL basic_id: got %0h expected 1", bus.Int_Id); else passed++;
        total++; if (bus.Int_Vector !== 16'h0110) $display("FAIL basic_vec: got %0h expected 0110", bus.Int_Vector); else passed++;
        bus.Int_Ack = 1'b1;
        tick();
        bus.Int_Ack = 1'b0;
        bus.Pending = 4'b1000;
        total++; if (bus.CLR !== 4'b0010) $display("FAIL basic_clr: got %0b expected 0010", bus.CLR); else passed++;
        total++; if (bus.In_Service !== 4'b0010) $display("FAIL basic_insvc: got %0b expected 0010", bus.In_Service); else passed++;
        total++; if (bus.Int_Req !== 1'b0) $display("FAIL basic_req_drop: got %0h expected 0", bus.Int_Req); else passed++;
        tick();
        total++; if (bus.CLR !== 4'b0000) $display("FAIL basic_clr_1cyc: got %0b expected 0000", bus.CLR); else passed++;
        total++; if (bus.Int_Req !== 1'b0) $display("FAIL basic_no_req_svc: got %0h expected 0", bus.Int_Req); else passed++;
    endtask

    task automatic test_mask();
        do_reset();
        bus.Mask    = 4'b0101;
        bus.Pending = 4'b1010;
        tick();
        tick();
        total++; if (bus.Int_Req !== 1'b0) $display("FAIL mask_block: got %0h expected 0", bus.Int_Req); else passed++;
        bus.Mask = 4'b1111;
        tick();
        total++; if (bus.Int_Req !== 1'b1 || bus.Int_Id !== 2'd1)
            $display("FAIL mask_open: got req=%0h id=%0h expected 1/1", bus.Int_Req, bus.Int_Id); else passed++;
        bus.Int_Ack = 1'b1;
        tick();
        bus.Int_Ack = 1'b0;
        bus.Pending = 4'b1000;
        tick();
        bus.Int_Return = 1'b1;
        tick();
        bus.Int_Return = 1'b0;
        total++; if (bus.In_Service !== 4'b0000) $display("FAIL mask_ret_insvc: got %0b expected 0000", bus.In_Service); else passed++;
        total++; if (bus.Int_Req !== 1'b0) $display("FAIL mask_ret_no_req: got %0h expected 0", bus.Int_Req); else passed++;
        tick();
        total++; if (bus.Int_Req !== 1'b1 || bus.Int_Id !== 2'd3)
            $display("FAIL mask_rearb: got req=%0h id=%0h expected 1/3", bus.Int_Req, bus.Int_Id); else passed++;
        total++; if (bus.Int_Vector !== 16'h0130) $display("FAIL mask_vec3: got %0h expected 0130", bus.Int_Vector); else passed++;
    endtask

    task automatic test_frozen();
        do_reset();
        bus.Pending = 4'b0100;
        tick();
        total++; if (bus.Int_Req !== 1'b1 || bus.Int_Id !== 2'd2)
            $display("FAIL frozen_req: got req=%0h id=%0h expected 1/2", bus.Int_Req, bus.Int_Id); else passed++;
        bus.Pending   = 4'b0000;
        bus.Global_En = 1'b0;
        tick();
        tick();
        total++; if (bus.Int_Req !== 1'b1 || bus.Int_Id !== 2'd2)
            $display("FAIL frozen_hold: got req=%0h id=%0h expected 1/2", bus.Int_Req, bus.Int_Id); else passed++;
        total++; if (bus.Int_Vector !== 16'h0120) $display("FAIL frozen_vec: got %0h expected 0120", bus.Int_Vector); else passed++;
        bus.Int_Ack = 1'b1;
        tick();
        bus.Int_Ack = 1'b0;
        total++; if (bus.CLR !== 4'b0100) $display("FAIL frozen_clr: got %0b expected 0100", bus.CLR); else passed++;
    endtask

    task automatic test_nesting();
        do_reset();
        bus.Pending = 4'b0100;
        tick();
        bus.Int_Ack = 1'b1;
        tick();
        bus.Int_Ack = 1'b0;
        bus.Pending = 4'b0001;
        total++; if (bus.In_Service !== 4'b0100) $display("FAIL nest_insvc2: got %0b expected 0100", bus.In_Service); else passed++;
        tick();
`ifdef INTERRUPT_CONTROLLER_NESTING_EN
        total++; if (bus.Int_Req !== 1'b1 || bus.Int_Id !== 2'd0)
            $display("FAIL nest_req0: got req=%0h id=%0h expected 1/0", bus.Int_Req, bus.Int_Id); else passed++;
        total++; if (bus.Int_Vector !== 16'h0100) $display("FAIL nest_vec0: got %0h expected 0100", bus.Int_Vector); else passed++;
        bus.Int_Ack = 1'b1;
        tick();
        bus.Int_Ack = 1'b0;
        bus.Pending = 4'b0000;
        total++; if (bus.In_Service !== 4'b0101) $display("FAIL nest_stack: got %0b expected 0101", bus.In_Service); else passed++;
        total++; if (bus.CLR !== 4'b0001) $display("FAIL nest_clr: got %0b expected 0001", bus.CLR); else passed++;
        bus.Int_Return = 1'b1;
        tick();
        total++; if (bus.In_Service !== 4'b0100) $display("FAIL nest_pop1: got %0b expected 0100", bus.In_Service); else passed++;
        tick();
        bus.Int_Return = 1'b0;
        total++; if (bus.In_Service !== 4'b0000) $display("FAIL nest_pop2: got %0b expected 0000", bus.In_Service); else passed++;
`else
        tick();
        tick();
        total++; if (bus.Int_Req !== 1'b0) $display("FAIL nonest_no_req: got %0h expected 0", bus.Int_Req); else passed++;
        bus.Int_Return = 1'b1;
        tick();
        bus.Int_Return = 1'b0;
        total++; if (bus.In_Service !== 4'b0000) $display("FAIL nonest_ret: got %0b expected 0000", bus.In_Service); else passed++;
        tick();
        total++; if (bus.Int_Req !== 1'b1 || bus.Int_Id !== 2'd0)
            $display("FAIL nonest_after: got req=%0h id=%0h expected 1/0", bus.Int_Req, bus.Int_Id); else passed++;
        total++; if (bus.Int_Vector !== 16'h0100) $display("FAIL nonest_vec0: got %0h expected 0100", bus.Int_Vector); else passed++;
`endif
    endtask

    task automatic test_reset_in_req();
        do_reset();
        bus.Pending = 4'b0010;
        tick();
        total++; if (bus.Int_Req !== 1'b1) $display("FAIL rreq_req: got %0h expected 1", bus.Int_Req); else passed++;
        bus.Int_Ack = 1'b1;
        Reset       = 1'b1;
        tick();
        bus.Int_Ack = 1'b0;
        Reset       = 1'b0;
        bus.Pending = 4'b0000;
        total++; if (bus.Int_Req !== 1'b0 || bus.CLR !== 4'b0000 || bus.In_Service !== 4'b0000)
            $display("FAIL rreq_abandon: got req=%0h clr=%0b insvc=%0b expected 0/0000/0000",
                     bus.Int_Req, bus.CLR, bus.In_Service); else passed++;
    endtask

    task automatic test_ignored();
        do_reset();
        bus.Int_Ack = 1'b1;
        tick();
        bus.Int_Ack = 1'b0;
        total++; if (bus.CLR !== 4'b0000 || bus.In_Service !== 4'b0000)
            $display("FAIL ign_ack: got clr=%0b insvc=%0b expected 0000/0000", bus.CLR, bus.In_Service); else passed++;
        bus.Int_Return = 1'b1;
        tick();
        bus.Int_Return = 1'b0;
        total++; if (bus.Int_Req !== 1'b0 || bus.In_Service !== 4'b0000)
            $display("FAIL ign_ret: got req=%0h insvc=%0b expected 0/0000", bus.Int_Req, bus.In_Service); else passed++;
        bus.Pending = 4'b1111;
        bus.Mask    = 4'b1100;
        tick();
        total++; if (bus.Int_Id !== 2'd2 || bus.Int_Vector !== 16'h0120)
            $display("FAIL ign_prio: got id=%0h vec=%0h expected 2/0120", bus.Int_Id, bus.Int_Vector); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_frozen();
        test_nesting();
        test_reset_in_req();
        test_ignored();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Sits between the 4-source interrupt pending register and the CPU control unit. It masks the pending bits and picks the highest-priority source. It then runs a request/acknowledge handshake with the CPU, supplying the handler vector, pulses that source's pending-register clear line, and tracks in-service state until the CPU signals return-from-interrupt.

Parameters:
VECTOR_BASE, 16'h0100, handler address for source 0
VECTOR_STRIDE, 16'h0010, address spacing between consecutive source handlers
ADDR_W, 16, width of Int_Vector

Ports:
CLK  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Pending  input  4  pending flags from the interrupt register; bit0 = highest priority, bit3 = lowest
Mask  input  4  per-source enable, 1 = enabled (from switches Sw3..Sw0)
Global_En  input  1  CPU global interrupt enable
Int_Ack  input  1  CPU accepts the current request (1-cycle pulse)
Int_Return  input  1  CPU executed return-from-interrupt (1-cycle pulse)
Int_Req  output  1  interrupt request to CPU
Int_Id  output  2  index of the requested source
Int_Vector  output  ADDR_W  VECTOR_BASE + Int_Id*VECTOR_STRIDE, truncated to ADDR_W
CLR  output  4  one-hot, 1-cycle clear pulse to the pending register
In_Service  output  4  sources currently being serviced

Behaviour:
- Reset (sync, active-high, dominates all inputs): state=IDLE; Int_Req=0, Int_Id=0, Int_Vector=0, CLR=0, In_Service=0. Reset asserted mid-handshake or mid-service abandons everything; no CLR is issued.
- Eligible = Pending & Mask & {4{Global_En}} & Allowed. Without nesting, Allowed = 4'b1111. Winner = lowest set index of Eligible.
- States: IDLE, REQ, SERVICE. All outputs are registered.
- IDLE: if Eligible != 0 at edge N, then from edge N (visible in cycle N+1):
  - Int_Req=1
  - Int_Id=winner
  - Int_Vector computed from winner
  - go to REQ.
  Latency is 1 cycle from an eligible pending bit to Int_Req.
- REQ: Int_Id/Int_Vector are frozen. No re-arbitration, and no withdrawal if Pending, Mask or Global_En drop. On Int_Ack:
  - Int_Req=0
  - CLR[Int_Id]=1 for exactly 1 cycle
  - In_Service[Int_Id]=1
  - go to SERVICE.
- SERVICE: On Int_Return, clear the lowest-index set bit of In_Service. If In_Service becomes 0, go to IDLE; re-arbitration occurs at the earliest on the edge after entry to IDLE. Without nesting, no new request is raised in SERVICE.
- Ignored events: Int_Ack outside REQ; Int_Return in IDLE; Int_Return in REQ when In_Service==0.
- CLR is 0 in every cycle except the single cycle following an accepted Int_Ack.
- A source whose pending bit is still set after its CLR pulse (re-asserted by a button) is eligible again once its In_Service bit clears.
- Int_Ack and Int_Return in the same cycle in REQ (nesting only): apply the return first (clear the lowest set In_Service bit), then set the new In_Service bit. Next state is SERVICE.

Optional Feature:
Macro: INTERRUPT_CONTROLLER_NESTING_EN
- Defined:
  - Allowed = sources with priority strictly higher than the lowest set index of In_Service; all ones when In_Service==0.
  - In SERVICE, Eligible != 0 raises Int_Req and moves to REQ. This can occur in the cycle after entering SERVICE.
  - Ack stacks In_Service bits, maximum depth 4. Each Int_Return pops the highest-priority active bit.
  - After the Int_Ack of a nested request, return to SERVICE (not IDLE).
- Undefined: Allowed = all ones, but SERVICE never raises requests. In_Service has at most one bit set.

Test Plan:
- Reset then Pending=4'b0000 for 10 cycles -> Int_Req=0, CLR=0, In_Service=0 throughout.
- Mask=4'b1111, Global_En=1, Pending=4'b1010 -> next cycle Int_Req=1, Int_Id=1, Int_Vector=16'h0110. Ack -> CLR=4'b0010 for 1 cycle, In_Service=4'b0010, Int_Req=0.
- Mask=4'b0101, Pending=4'b1010 -> no request. Mask changed to 4'b1111 -> Int_Id=1. Ack then Int_Return -> In_Service=0, state IDLE. Pending bit3 still set -> request Int_Id=3, Int_Vector=16'h0130.
- Request up with Int_Id=2, then Pending drops to 0 and Global_En=0 before Ack -> Int_Req stays 1 with Int_Id=2. Ack -> CLR=4'b0100.
- Nesting: in service of source 2, Pending bit0 rises -> Int_Req=1, Int_Id=0. Ack -> In_Service=4'b0101. Return -> 4'b0100. Return -> 4'b0000. Without macro: no request while source 2 is in service.
- Reset asserted in REQ the cycle Int_Ack is high -> next cycle Int_Req=0, CLR=0, In_Service=0.
